// File: rtl/winewhite_bnn1_bnn_parw_if.sv
// Streaming port bundle for the white-wine BNN classifier: feature vectors in,
// class predictions out, no backpressure in either direction.
interface winewhite_bnn1_bnn_parw_if #(
    parameter int FEAT_CNT  = 11,
    parameter int FEAT_BITS = 4,
    parameter int CLASS_CNT = 7,
    parameter int PRED_BITS = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
);
    logic                          in_valid;
    logic [FEAT_CNT*FEAT_BITS-1:0] features;
    logic                          out_valid;
    logic [PRED_BITS-1:0]          prediction;

    modport master (
        output in_valid,
        output features,
        input  out_valid,
        input  prediction
    );

    modport slave (
        input  in_valid,
        input  features,
        output out_valid,
        output prediction
    );
endinterface

// File: rtl/winewhite_bnn1_bnn_parw.sv
// Two-stage binarized classifier: +/-1 hidden layer with sign activation, then
// XNOR-popcount class scores and lowest-index-wins argmax.
module winewhite_bnn1_bnn_parw #(
    parameter int FEAT_CNT   = 11,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 7,
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '1,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0
) (
    input logic                      clk,
    input logic                      rst_n,
    winewhite_bnn1_bnn_parw_if.slave bus
);
    localparam int PRED_BITS  = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
    localparam int SUM_W      = FEAT_BITS + $clog2(FEAT_CNT + 1) + 1;
    localparam int SCORE_W    = $clog2(HIDDEN_CNT + 1);
    localparam int FEAT_W     = FEAT_CNT * FEAT_BITS;

    logic [FEAT_W-1:0]           feat_d, feat_q;
    logic                        valid_d, valid_q;
    logic [PRED_BITS-1:0]        pred_d, pred_q;
    logic                        out_valid_d, out_valid_q;

    logic signed [SUM_W-1:0]     sum [HIDDEN_CNT];
    logic [HIDDEN_CNT-1:0]       hid;
    logic [SCORE_W-1:0]          score [CLASS_CNT];
    logic [HIDDEN_CNT-1:0]       agree [CLASS_CNT];
    logic [SCORE_W-1:0]          best;
    logic [PRED_BITS-1:0]        win;

    always_comb begin
        feat_d  = bus.features;
        valid_d = bus.in_valid;
    end

    // Features are zero-extended into a signed accumulator; a zero sum is
    // treated as positive so the activation is simply the inverted sign bit.
    always_comb begin
        hid = '0;
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            sum[h] = '0;
            for (int f = 0; f < FEAT_CNT; f++) begin
                if (W1[h*FEAT_CNT + f]) begin
                    sum[h] = sum[h] + $signed({{(SUM_W-FEAT_BITS){1'b0}},
                                               feat_q[f*FEAT_BITS +: FEAT_BITS]});
                end else begin
                    sum[h] = sum[h] - $signed({{(SUM_W-FEAT_BITS){1'b0}},
                                               feat_q[f*FEAT_BITS +: FEAT_BITS]});
                end
            end
            hid[h] = ~sum[h][SUM_W-1];
        end
    end

    always_comb begin
        for (int c = 0; c < CLASS_CNT; c++) begin
            agree[c] = ~(hid ^ W2[c*HIDDEN_CNT +: HIDDEN_CNT]);
            score[c] = '0;
            for (int h = 0; h < HIDDEN_CNT; h++) begin
                score[c] = score[c] + SCORE_W'(agree[c][h]);
            end
        end
    end

    // Strict greater-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        best = score[0];
        win  = '0;
        for (int c = 1; c < CLASS_CNT; c++) begin
            if (score[c] > best) begin
                best = score[c];
                win  = PRED_BITS'(c);
            end
        end
    end

    always_comb begin
        pred_d      = win;
        out_valid_d = valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q      <= '0;
            valid_q     <= 1'b0;
            pred_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            feat_q      <= feat_d;
            valid_q     <= valid_d;
            pred_q      <= pred_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.prediction = pred_q;
    assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_winewhite_bnn1_bnn_parw.sv
// Directed bench: several classifier instances with hand-built weight sets,
// plus a streamed run against a reference model of the network.
module tb_winewhite_bnn1_bnn_parw;
    localparam int FC = 11;
    localparam int FB = 4;
    localparam int HC = 40;
    localparam int CC = 7;
    localparam int N_STREAM = 1000;

    localparam logic [HC*FC-1:0] W1_ONES  = '1;
    localparam logic [HC*FC-1:0] W1_ZEROS = '0;
    localparam logic [HC*FC-1:0] W1_MIXED = {HC{11'b000_0000_0001}};
    localparam logic [CC*HC-1:0] W2_T3    = {40'h0, 40'h0, 40'h0, {40{1'b1}}, 40'h0, 40'h0, 40'h0};
    localparam logic [CC*HC-1:0] W2_T4    = {40'h0, {240{1'b1}}};
    localparam logic [CC*HC-1:0] W2_T5    = {40'h0, 40'hFFFFF00000, 40'h0, 40'h0,
                                             40'h00000FFFFF, 40'h0, 40'h0};
    localparam logic [HC*FC-1:0] W1_R     = {11{40'hA53C96E17B}};
    localparam logic [CC*HC-1:0] W2_R     = {40'h5555AAAA55, 40'h9999966666, 40'h3C3C3CC3C3,
                                             40'hA5A5A5A5A5, 40'h0F0F0F0F0F, 40'hFEDCBA9876,
                                             40'h1234567890};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [2:0] exp_pred [N_STREAM];

    winewhite_bnn1_bnn_parw_if if2 ();
    winewhite_bnn1_bnn_parw_if if3 ();
    winewhite_bnn1_bnn_parw_if if4 ();
    winewhite_bnn1_bnn_parw_if if5 ();
    winewhite_bnn1_bnn_parw_if ifs ();

    winewhite_bnn1_bnn_parw dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    winewhite_bnn1_bnn_parw #(.W1(W1_ONES),  .W2(W2_T3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    winewhite_bnn1_bnn_parw #(.W1(W1_ZEROS), .W2(W2_T4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    winewhite_bnn1_bnn_parw #(.W1(W1_MIXED), .W2(W2_T5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
    winewhite_bnn1_bnn_parw #(.W1(W1_R),     .W2(W2_R))  duts (.clk(clk), .rst_n(rst_n), .bus(ifs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts each hidden neuron's positive and negative contributions
    // separately, then scores classes by counting agreeing hidden bits.
    function automatic logic [2:0] model(input logic [FC*FB-1:0] feat);
        logic [HC-1:0] h_bits;
        int pos, neg, sc, best, win;
        for (int h = 0; h < HC; h++) begin
            pos = 0;
            neg = 0;
            for (int f = 0; f < FC; f++) begin
                if (W1_R[h*FC + f]) pos += int'(feat[f*FB +: FB]);
                else                neg += int'(feat[f*FB +: FB]);
            end
            h_bits[h] = (pos >= neg);
        end
        best = -1;
        win  = 0;
        for (int c = 0; c < CC; c++) begin
            sc = 0;
            for (int h = 0; h < HC; h++) begin
                if (h_bits[h] == W2_R[c*HC + h]) sc++;
            end
            if (sc > best) begin
                best = sc;
                win  = c;
            end
        end
        return 3'(win);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [FC*FB-1:0] f);
        ifs.in_valid = v;
        ifs.features = f;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        logic [FC*FB-1:0] vec;
        int i;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        if2.in_valid = 1'b0; if2.features = '0;
        if3.in_valid = 1'b0; if3.features = '0;
        if4.in_valid = 1'b0; if4.features = '0;
        if5.in_valid = 1'b0; if5.features = '0;
        applyStimulus(1'b0, '0);

        step(2);
        checkOutput("reset_pred", 32'(if3.prediction), 0);
        checkOutput("reset_valid", 32'(if3.out_valid), 0);
        rst_n = 1'b1;

        $display("[TB] directed weight sets");
        if2.in_valid = 1'b1; if2.features = '0;
        if3.in_valid = 1'b1; if3.features = {FC{4'h5}};
        if4.in_valid = 1'b0; if4.features = {FC{4'hF}};
        if5.in_valid = 1'b1; if5.features = {{(FC-1){4'h1}}, 4'hF};
        step(1);
        checkOutput("first_valid_early", 32'(if3.out_valid), 0);
        step(1);
        checkOutput("t3_valid", 32'(if3.out_valid), 1);
        checkOutput("t3_pred", 32'(if3.prediction), 3);
        checkOutput("t2_valid", 32'(if2.out_valid), 1);
        checkOutput("t2_pred", 32'(if2.prediction), 0);
        checkOutput("t4_pred_invalid", 32'(if4.prediction), 6);
        checkOutput("t4_valid_low", 32'(if4.out_valid), 0);
        checkOutput("t5_pred", 32'(if5.prediction), 2);

        if4.in_valid = 1'b1;
        if5.features = {{(FC-1){4'h1}}, 4'hA};
        step(2);
        checkOutput("t4_valid", 32'(if4.out_valid), 1);
        checkOutput("t4_pred", 32'(if4.prediction), 6);
        checkOutput("t5_zero_sum", 32'(if5.prediction), 2);

        if5.features = {{(FC-1){4'h1}}, 4'h9};
        step(2);
        checkOutput("t5_neg_sum", 32'(if5.prediction), 0);

        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_pred", 32'(if3.prediction), 0);
        checkOutput("midreset_valid", 32'(if3.out_valid), 0);
        checkOutput("midreset_pred5", 32'(if5.prediction), 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        checkOutput("post_reset_early", 32'(if3.out_valid), 0);
        step(1);
        checkOutput("post_reset_valid", 32'(if3.out_valid), 1);
        checkOutput("post_reset_pred", 32'(if3.prediction), 3);

        $display("[TB] streaming %0d vectors", N_STREAM);
        for (i = 0; i < N_STREAM + 2; i++) begin
            if (i >= 2) begin
                checkOutput("stream_valid", 32'(ifs.out_valid), 1);
                checkOutput("stream_pred", 32'(ifs.prediction), 32'(exp_pred[i-2]));
            end
            if (i < N_STREAM) begin
                for (int f = 0; f < FC; f++) vec[f*FB +: FB] = 4'($urandom_range(15, 0));
                exp_pred[i] = model(vec);
                applyStimulus(1'b1, vec);
            end else begin
                applyStimulus(1'b0, vec);
            end
            step(1);
        end
        checkOutput("stream_drain", 32'(ifs.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
